systolic_result_drain: RTL and testbench

//   Output-side companion of the 1xN systolic MAC array (systolic1x4 when N_PE=4).
//   - Counts operand beats fed into the array and waits for the pipeline skew to settle.
//   - Snapshots all N_PE accumulators c0..c{N-1}, then streams them out one per beat over valid/ready.
//   - Pulses acc_clear so the array starts the next job from zero.

---
 rtl/systolic_pkg.sv | 22 ++
 rtl/systolic_result_drain.sv | 176 +++++++++++++++++
 tb/tb_systolic_result_drain.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC array and its result drain.
package systolic_pkg;

  localparam int N_PE_DEF  = 4;
  localparam int ACC_W_DEF = 32;
  localparam int CNT_W_DEF = 16;

  // Width of a PE index; a single-PE array still needs one bit.
  function automatic int pe_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PE_IDX_W = pe_idx_w(N_PE_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    SETTLE = 2'd2,
    DRAIN  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/systolic_result_drain.sv
// Result drain for the 1xN systolic MAC array: counts operand beats, waits out
// the array skew, snapshots every accumulator and streams them out in order.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no job; the first operand beat starts one
// COUNT  | operand beats arriving, job_len counting
// SETTLE | last beat seen, waiting for it to reach the final PE
// DRAIN  | snapshot held, streaming snap[0..N_PE-1] over valid/ready
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int N_PE  = N_PE_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int IDX_W = pe_idx_w(N_PE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [N_PE*ACC_W-1:0] acc_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  acc_clear,
  output logic [CNT_W-1:0]      job_len,
  output logic                  busy,
  output logic                  err_overrun
);

  localparam logic [CNT_W-1:0] JOB_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PE - 1);

  drain_state_e state, state_nxt;

  logic [IDX_W-1:0] settle_cnt;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] snap [N_PE];

  // Control strobes decoded from state and handshakes
  logic job_start;
  logic job_beat;
  logic last_accept;
  logic settle_done;
  logic beat_out;
  logic drain_done;
  logic overrun_hit;

  // Decode the per-cycle events the datapath registers react to
  always_comb begin
    job_start   = (state == IDLE) && in_valid;
    job_beat    = (state == COUNT) && in_valid;
    last_accept = ((state == IDLE) || (state == COUNT)) && in_valid && in_last;
    settle_done = (state == SETTLE) && (settle_cnt == '0);
    beat_out    = (state == DRAIN) && out_ready;
    drain_done  = beat_out && (idx == IDX_LAST);
    // Beats outside IDLE/COUNT are dropped, and a saturated counter cannot
    // record another beat; either way the job length is no longer exact.
    overrun_hit = (in_valid && ((state == SETTLE) || (state == DRAIN))) ||
                  (job_beat && (job_len == JOB_MAX));
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = in_last ? SETTLE : COUNT;
        end
      end
      COUNT: begin
        if (in_valid && in_last) begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: stream side is purely a function of state and drain index
  always_comb begin
    out_valid = (state == DRAIN);
    busy      = (state != IDLE);
    out_idx   = idx;
    out_data  = snap[idx];
    out_last  = (state == DRAIN) && (idx == IDX_LAST);
  end

  // Job beat counter; holds the last job's length until the next job starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_len <= '0;
    end else if (job_start) begin
      job_len <= CNT_W'(1);
    end else if (job_beat && (job_len != JOB_MAX)) begin
      job_len <= job_len + CNT_W'(1);
    end
  end

  // Sticky overrun flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overrun <= 1'b0;
    end else if (overrun_hit) begin
      err_overrun <= 1'b1;
    end
  end

  // Skew timer: loaded on the last-beat edge so the snapshot lands N_PE edges later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (last_accept) begin
      settle_cnt <= IDX_LAST;
    end else if ((state == SETTLE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - IDX_W'(1);
    end
  end

  // Drain index: restarts at 0 with each snapshot, advances per accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (settle_done) begin
      idx <= '0;
    end else if (beat_out) begin
      idx <= drain_done ? '0 : idx + IDX_W'(1);
    end
  end

  // Snapshot bank: all lanes captured together so later array activity is invisible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PE; i++) begin
        snap[i] <= '0;
      end
    end else if (settle_done) begin
      for (int i = 0; i < N_PE; i++) begin
        snap[i] <= acc_in[i*ACC_W +: ACC_W];
      end
    end
  end

  // Array clear pulse in the cycle after the final beat is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_clear <= 1'b0;
    end else begin
      acc_clear <= drain_done;
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain with a behavioural 1x4 MAC array.
module tb_systolic_result_drain;

  localparam int N     = 4;
  localparam int ACC_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic [N*ACC_W-1:0] acc_in;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ACC_W-1:0]  out_data;
  logic [1:0]        out_idx;
  logic              out_last;
  logic              acc_clear;
  logic [15:0]       job_len;
  logic              busy;
  logic              err_overrun;

  // narrow-counter instance, used for the saturation case
  logic              out_valid2;
  logic [ACC_W-1:0]  out_data2;
  logic [1:0]        out_idx2;
  logic              out_last2;
  logic              acc_clear2;
  logic [1:0]        job_len2;
  logic              busy2;
  logic              err_overrun2;

  logic [31:0] a_op [N];
  logic [31:0] b0 = '0;
  logic [31:0] c    [N];
  logic        vp   [N-1];
  logic [31:0] bp   [N-1];
  logic [31:0] bvec [8];

  int cyc = 0;
  int last_cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  systolic_result_drain #(.N_PE(4), .ACC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .acc_in(acc_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .acc_clear(acc_clear), .job_len(job_len), .busy(busy),
    .err_overrun(err_overrun)
  );

  systolic_result_drain #(.N_PE(4), .ACC_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .acc_in(acc_in), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_idx(out_idx2), .out_last(out_last2),
    .acc_clear(acc_clear2), .job_len(job_len2), .busy(busy2),
    .err_overrun(err_overrun2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 1x4 array: lane i sees the operand beat i edges after lane 0
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || acc_clear) begin
      for (int i = 0; i < N; i++) c[i] <= '0;
      for (int i = 0; i < N-1; i++) begin vp[i] <= 1'b0; bp[i] <= '0; end
    end else begin
      if (in_valid) c[0] <= c[0] + a_op[0] * b0;
      for (int i = 1; i < N; i++) begin
        if (vp[i-1]) c[i] <= c[i] + a_op[i] * bp[i-1];
      end
      vp[0] <= in_valid;
      bp[0] <= b0;
      for (int i = 1; i < N-1; i++) begin vp[i] <= vp[i-1]; bp[i] <= bp[i-1]; end
    end
  end

  always_comb begin
    acc_in = '0;
    for (int i = 0; i < N; i++) acc_in[i*ACC_W +: ACC_W] = c[i];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_a(input logic [31:0] v);
    for (int i = 0; i < N; i++) a_op[i] = v;
  endtask

  // Feed n beats from bvec; returns at #1 after the last-beat edge
  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_last  = (i == n-1);
      b0       = bvec[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    b0       = '0;
    last_cyc = cyc;
  endtask

  // Collect up to stop_at beats; optional stall on one index, optional
  // in_valid poke while draining, optional first-valid latency check.
  task automatic drain_check(input logic [31:0] exp, input int stall_idx, input int stall_n,
                             input int poke_idx, input int stop_at, input int exp_lat);
    int got = 0;
    int stall_left = stall_n;
    int guard = 0;
    bit poked = 0;
    bit seen = 0;
    out_ready = 1'b1;
    while (got < stop_at && guard < 60) begin
      in_valid = 1'b0;
      b0 = '0;
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          if (exp_lat > 0) chk("first_valid_latency", cyc + 1 - last_cyc, exp_lat);
        end
        if (got == poke_idx && !poked) begin
          in_valid = 1'b1;
          b0 = 32'd1;
          poked = 1;
        end
        chk("drain_data", out_data, exp);
        chk("drain_idx", out_idx, got);
        if (got == stall_idx && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          chk("drain_last", out_last, (got == N-1));
          got++;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("drain_beat_count", got, stop_at);
    if (stop_at == N) begin
      chk("acc_clear_pulse", acc_clear, 1);
      chk("busy_after_drain", busy, 0);
      @(posedge clk); #1;
      chk("acc_clear_one_cycle", acc_clear, 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    set_a(32'd0);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_job_len", job_len, 0);
    chk("rst_err", err_overrun, 0);
    chk("rst_acc_clear", acc_clear, 0);
    chk("rst_out_data", out_data, 0);
    do_reset();

    // 1: a=5, b0=5,10,20 -> 5*35 = 175 in every lane
    set_a(32'd5);
    bvec[0] = 32'd5; bvec[1] = 32'd10; bvec[2] = 32'd20;
    feed(3);
    chk("t1_job_len", job_len, 3);
    chk("t1_busy_settle", busy, 1);
    chk("t1_no_valid_yet", out_valid, 0);
    drain_check(32'd175, -1, 0, -1, N, N+1);
    chk("t1_job_len_after", job_len, 3);

    // 2: same job, out_ready low 3 cycles on idx1
    feed(3);
    drain_check(32'd175, 1, 3, -1, N, N+1);
    chk("t2_err_clear", err_overrun, 0);

    // 3: single-beat job, 3*7 = 21
    set_a(32'd3);
    bvec[0] = 32'd7;
    feed(1);
    chk("t3_job_len", job_len, 1);
    drain_check(32'd21, -1, 0, -1, N, N+1);

    // 4: in_valid pulsed during drain
    set_a(32'd5);
    bvec[0] = 32'd5; bvec[1] = 32'd10; bvec[2] = 32'd20;
    feed(3);
    chk("t4_err_before", err_overrun, 0);
    drain_check(32'd175, -1, 0, 1, N, N+1);
    chk("t4_err_set", err_overrun, 1);
    chk("t4_job_len_uncounted", job_len, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_err_sticky", err_overrun, 1);

    // 5: reset in the middle of a drain, after idx1 accepted
    feed(3);
    drain_check(32'd175, -1, 0, -1, 2, N+1);
    rst_n = 1'b0;
    #1;
    chk("t5_valid_drop", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_job_len", job_len, 0);
    chk("t5_err", err_overrun, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    feed(3);
    drain_check(32'd175, -1, 0, -1, N, N+1);

    // 6: narrow counter saturates on a 5-beat job, 5*5 = 25 per lane
    do_reset();
    set_a(32'd5);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_last  = (i == 4);
      b0       = 32'd1;
      @(posedge clk); #1;
      if (i == 2) begin
        chk("t6_len_at3", job_len2, 3);
        chk("t6_err_at3", err_overrun2, 0);
      end
      if (i == 3) begin
        chk("t6_len_sat", job_len2, 3);
        chk("t6_err_at4", err_overrun2, 1);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    b0       = '0;
    last_cyc = cyc;
    chk("t6_len_final", job_len2, 3);
    chk("t6_wide_len", job_len, 5);
    chk("t6_wide_err", err_overrun, 0);
    drain_check(32'd25, -1, 0, -1, N, N+1);
    chk("t6_err_sticky", err_overrun2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
